// File: rtl/hazard_fwd_scoreboard.sv
// hazard_fwd_scoreboard
// Operand forwarding select for the EX stage across NUM_STAGES write-back
// sources (nearest stage wins), a per-register countdown scoreboard that
// stalls ID on multi-cycle results, and a saturating stall-cycle counter.
// There is no FSM here: the scoreboard is a bank of independent down-counters.
module hazard_fwd_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = 2,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_STAGES-1:0]        stage_we,
  input  logic [NUM_STAGES*REG_AW-1:0] stage_rd,
  input  logic [REG_AW-1:0]            ex_rs1,
  input  logic [REG_AW-1:0]            ex_rs2,
  output logic [SEL_W-1:0]             fwd_a,
  output logic [SEL_W-1:0]             fwd_b,
  input  logic                         id_valid,
  input  logic [REG_AW-1:0]            id_rs1,
  input  logic [REG_AW-1:0]            id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic                         id_we,
  input  logic [REG_AW-1:0]            id_rd,
  input  logic [LAT_W-1:0]             id_lat,
  input  logic                         pipe_hold,
  input  logic                         flush,
  input  logic                         cnt_clr,
  output logic                         stall,
  output logic [(1<<REG_AW)-1:0]       busy_vec,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int NREG = 1 << REG_AW;

  logic [LAT_W-1:0] cnt [NREG];
  logic             rs1_busy;
  logic             rs2_busy;
  logic             issue;
  logic             load_hit;

  // Forward select: scan oldest to youngest so the youngest matching stage overrides
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_we[i] && (stage_rd[i*REG_AW +: REG_AW] != '0)) begin
        if (stage_rd[i*REG_AW +: REG_AW] == ex_rs1) fwd_a = SEL_W'(i + 1);
        if (stage_rd[i*REG_AW +: REG_AW] == ex_rs2) fwd_b = SEL_W'(i + 1);
      end
    end
  end

  // Hazard detect and issue qualification; cnt[0] is held at zero so x0 never stalls
  always_comb begin
    rs1_busy = id_use_rs1 && (cnt[id_rs1] != '0);
    rs2_busy = id_use_rs2 && (cnt[id_rs2] != '0);
    stall    = id_valid && (rs1_busy || rs2_busy);
    issue    = id_valid && !stall && !pipe_hold && !flush;
    load_hit = issue && id_we && (id_rd != '0);
  end

  // Scoreboard countdowns: flush clears, hold freezes, otherwise tick down;
  // a new issue to the same rd overrides the decrement (later write wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (!pipe_hold) begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          cnt[r] <= '0;
        end else if (load_hit && (id_rd == REG_AW'(r))) begin
          cnt[r] <= id_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Busy view of the scoreboard for the hazard network
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt[r] != '0);
  end

  // Stall performance counter: clear wins, counts only cycles that really cost a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && !pipe_hold && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
module tb_hazard_fwd_scoreboard;

  localparam int REG_AW = 5;
  localparam int NS     = 2;
  localparam int SEL_W  = 2;
  localparam int LAT_W  = 3;
  localparam int NREG   = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NS-1:0]          stage_we;
  logic [NS*REG_AW-1:0]   stage_rd;
  logic [REG_AW-1:0]      ex_rs1, ex_rs2;
  logic [SEL_W-1:0]       fwd_a, fwd_b, fwd_a4, fwd_b4;
  logic                   id_valid, id_use_rs1, id_use_rs2, id_we;
  logic [REG_AW-1:0]      id_rs1, id_rs2, id_rd;
  logic [LAT_W-1:0]       id_lat;
  logic                   pipe_hold, flush, cnt_clr;
  logic                   stall, stall4;
  logic [NREG-1:0]        busy_vec, busy_vec4;
  logic [15:0]            stall_cnt;
  logic [3:0]             stall_cnt4;

  int checks = 0;
  int failures = 0;

  hazard_fwd_scoreboard #(.REG_AW(5), .NUM_STAGES(2), .SEL_W(2), .LAT_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stage_we(stage_we), .stage_rd(stage_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_we(id_we),
    .id_rd(id_rd), .id_lat(id_lat), .pipe_hold(pipe_hold), .flush(flush),
    .cnt_clr(cnt_clr), .stall(stall), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  hazard_fwd_scoreboard #(.REG_AW(5), .NUM_STAGES(2), .SEL_W(2), .LAT_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stage_we(stage_we), .stage_rd(stage_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_we(id_we),
    .id_rd(id_rd), .id_lat(id_lat), .pipe_hold(pipe_hold), .flush(flush),
    .cnt_clr(cnt_clr), .stall(stall4), .busy_vec(busy_vec4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] we;
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } fwd_vec_t;

  fwd_vec_t tbl [8];

  // reference model: a register is ready once the count of non-frozen cycles reaches ready_at
  int ready_at [NREG];
  int t_active;
  int m_sc16;
  int m_sc4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    stage_we = '0; stage_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_we = 1'b0; id_rd = '0; id_lat = '0; pipe_hold = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic [2:0] lat);
    id_valid = 1'b1; id_we = 1'b1; id_rd = rd; id_lat = lat;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
  endtask

  task automatic drive_dependant(input logic [4:0] rs);
    id_valid = 1'b1; id_we = 1'b0; id_rs1 = rs; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
  endtask

  function automatic int nearest(input logic [1:0] we, input logic [9:0] rd, input logic [4:0] rs);
    for (int i = 0; i < NS; i++) begin
      logic [4:0] r;
      r = rd[i*5 +: 5];
      if (we[i] && r != 0 && r == rs) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit m_busy(input int r);
    return (r != 0) && (ready_at[r] > t_active);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_stall;
    logic m_stall;
    logic [NREG-1:0] m_bv;

    tbl[0] = '{2'b11, 5'd5,  5'd5,  5'd5,  5'd5,  2'd1, 2'd1};
    tbl[1] = '{2'b10, 5'd5,  5'd5,  5'd5,  5'd5,  2'd2, 2'd2};
    tbl[2] = '{2'b11, 5'd3,  5'd4,  5'd3,  5'd4,  2'd1, 2'd2};
    tbl[3] = '{2'b11, 5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0};
    tbl[4] = '{2'b00, 5'd5,  5'd5,  5'd5,  5'd5,  2'd0, 2'd0};
    tbl[5] = '{2'b01, 5'd6,  5'd6,  5'd6,  5'd2,  2'd1, 2'd0};
    tbl[6] = '{2'b11, 5'd0,  5'd8,  5'd0,  5'd8,  2'd0, 2'd2};
    tbl[7] = '{2'b11, 5'd31, 5'd31, 5'd31, 5'd30, 2'd1, 2'd0};

    idle_inputs();
    #12;
    check("reset_busy_vec", 64'(busy_vec), 64'd0);
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    drive_dependant(5'd7);
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    idle_inputs();
    tick();

    // forwarding vectors
    for (int k = 0; k < 8; k++) begin
      stage_we = tbl[k].we;
      stage_rd = {tbl[k].rd1, tbl[k].rd0};
      ex_rs1 = tbl[k].rs1;
      ex_rs2 = tbl[k].rs2;
      #1;
      check($sformatf("fwd_a_vec%0d", k), 64'(fwd_a), 64'(tbl[k].exp_a));
      check($sformatf("fwd_b_vec%0d", k), 64'(fwd_b), 64'(tbl[k].exp_b));
    end
    idle_inputs();
    tick();

    // load-use: one stall cycle
    drive_issue(5'd7, 3'd1);
    tick();
    drive_dependant(5'd7);
    #1;
    check("loaduse_stall", 64'(stall), 64'd1);
    check("loaduse_busy7", 64'(busy_vec[7]), 64'd1);
    tick();
    check("loaduse_stall_after", 64'(stall), 64'd0);
    check("loaduse_busy7_after", 64'(busy_vec[7]), 64'd0);
    check("loaduse_stall_cnt", 64'(stall_cnt), 64'd1);
    idle_inputs();
    tick();

    // multi-cycle with two frozen cycles
    drive_issue(5'd9, 3'd4);
    tick();
    drive_dependant(5'd9);
    n_stall = 0;
    for (int k = 0; k < 20; k++) begin
      pipe_hold = (k == 1 || k == 2);
      #1;
      if (!stall) break;
      n_stall++;
      tick();
    end
    check("multi_stall_cycles", 64'(n_stall), 64'd6);
    check("multi_stall_cnt", 64'(stall_cnt), 64'd5);
    idle_inputs();
    tick();

    // WAW: ALU write clears pending entry
    drive_issue(5'd9, 3'd4);
    tick();
    check("waw_busy9_before", 64'(busy_vec[9]), 64'd1);
    drive_issue(5'd9, 3'd0);
    tick();
    check("waw_busy9_after", 64'(busy_vec[9]), 64'd0);
    idle_inputs();
    tick();

    // flush drops pending entries and the instruction present during flush
    drive_issue(5'd10, 3'd5);
    tick();
    drive_issue(5'd11, 3'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_dependant(5'd10);
    #1;
    check("flush_busy_vec", 64'(busy_vec), 64'd0);
    check("flush_stall", 64'(stall), 64'd0);
    idle_inputs();
    tick();

    // asynchronous reset mid-countdown
    drive_issue(5'd12, 3'd7);
    tick();
    idle_inputs();
    check("prereset_busy12", 64'(busy_vec[12]), 64'd1);
    check("prereset_stall_cnt", 64'(stall_cnt), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy_vec", 64'(busy_vec), 64'd0);
    check("async_reset_stall_cnt", 64'(stall_cnt), 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // saturation of the 4-bit counter: three rounds of seven stall cycles
    for (int round = 0; round < 3; round++) begin
      drive_issue(5'd13, 3'd7);
      tick();
      drive_dependant(5'd13);
      for (int k = 0; k < 7; k++) tick();
      if (round == 1) check("sat_cnt4_14", 64'(stall_cnt4), 64'd14);
    end
    check("sat_cnt4_15", 64'(stall_cnt4), 64'd15);
    check("sat_cnt16_21", 64'(stall_cnt), 64'd21);
    idle_inputs();
    cnt_clr = 1'b1;
    tick();
    check("clr_cnt4", 64'(stall_cnt4), 64'd0);
    check("clr_cnt16", 64'(stall_cnt), 64'd0);
    cnt_clr = 1'b0;

    // clear wins over increment
    drive_issue(5'd14, 3'd2);
    tick();
    drive_dependant(5'd14);
    cnt_clr = 1'b1;
    tick();
    check("clr_priority", 64'(stall_cnt), 64'd0);
    cnt_clr = 1'b0;
    tick();
    check("clr_then_count", 64'(stall_cnt), 64'd1);
    idle_inputs();

    // randomized run against the reference model
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    t_active = 0;
    m_sc16 = 0;
    m_sc4 = 0;
    tick();

    for (int cyc = 0; cyc < 2000; cyc++) begin
      stage_we   = 2'($urandom);
      stage_rd   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_rs1     = 5'($urandom_range(0, 7));
      ex_rs2     = 5'($urandom_range(0, 7));
      id_valid   = ($urandom_range(0, 9) < 8);
      id_rs1     = 5'($urandom_range(0, 7));
      id_rs2     = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      id_we      = ($urandom_range(0, 3) != 0);
      id_rd      = 5'($urandom_range(0, 7));
      id_lat     = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      pipe_hold  = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      cnt_clr    = ($urandom_range(0, 59) == 0);
      #1;

      m_stall = id_valid && ((id_use_rs1 && m_busy(int'(id_rs1))) ||
                             (id_use_rs2 && m_busy(int'(id_rs2))));
      for (int r = 0; r < NREG; r++) m_bv[r] = m_busy(r);

      check("rnd_fwd_a", 64'(fwd_a), 64'(nearest(stage_we, stage_rd, ex_rs1)));
      check("rnd_fwd_b", 64'(fwd_b), 64'(nearest(stage_we, stage_rd, ex_rs2)));
      check("rnd_stall", 64'(stall), 64'(m_stall));
      check("rnd_busy_vec", 64'(busy_vec), 64'(m_bv));
      check("rnd_stall_cnt", 64'(stall_cnt), 64'(m_sc16));
      check("rnd_stall_cnt4", 64'(stall_cnt4), 64'(m_sc4));

      if (cnt_clr) begin
        m_sc16 = 0;
        m_sc4 = 0;
      end else if (m_stall && !pipe_hold && !flush) begin
        if (m_sc16 < 65535) m_sc16++;
        if (m_sc4 < 15) m_sc4++;
      end

      if (flush) begin
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      end else if (!pipe_hold) begin
        t_active++;
        if (id_valid && !m_stall && id_we && id_rd != 0)
          ready_at[id_rd] = t_active + int'(id_lat);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_scoreboard.md
Name: hazard_fwd_scoreboard

Overview:
- Parametrised successor to the single-pair EX/MEM–MEM/WB forwarding unit.
- Resolves forwarding for both EX operands independently across NUM_STAGES write-back sources, nearest stage winning.
- Holds a per-register countdown scoreboard for multi-cycle results (loads, mul/div) and raises the ID stall.
- Keeps a saturating stall-cycle performance counter. Sits between ID/EX pipeline registers and the hazard/stall network.

Parameters:
- REG_AW, 5, register address width; the scoreboard has 2^REG_AW entries, and x0 is never busy.
- NUM_STAGES, 2, forwarding sources; index 0 is the youngest (EX/MEM), higher indices are older.
- SEL_W, 2, forward-select width; must satisfy 2^SEL_W >= NUM_STAGES+1.
- LAT_W, 3, width of the latency field and of each countdown.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stage_we  in  NUM_STAGES  RegWrite of each forwarding stage
- stage_rd  in  NUM_STAGES*REG_AW  rd of each stage; stage i occupies bits [i*REG_AW +: REG_AW]
- ex_rs1  in  REG_AW  rs1 of the instruction in EX
- ex_rs2  in  REG_AW  rs2 of the instruction in EX
- fwd_a  out  SEL_W  operand A select; 0 = register file, k = stage k-1
- fwd_b  out  SEL_W  operand B select, same encoding as fwd_a
- id_valid  in  1  valid instruction in ID
- id_rs1  in  REG_AW  ID source 1
- id_rs2  in  REG_AW  ID source 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_we  in  1  ID instruction writes rd
- id_rd  in  REG_AW  ID destination
- id_lat  in  LAT_W  extra cycles before the result is forwardable; 0 = ALU op
- pipe_hold  in  1  global freeze from a downstream stall
- flush  in  1  kill all in-flight long-latency ops
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall  out  1  ID must hold; combinational
- busy_vec  out  2^REG_AW  bit r = (cnt[r] != 0)
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Forwarding (combinational, zero latency):
  - For each operand independently, pick the lowest i with stage_we[i] && stage_rd[i] != 0 && stage_rd[i] == ex_rsX. Drive fwd = i+1; if no stage matches, drive 0.
  - fwd_a and fwd_b never suppress each other. When both operands match the same stage, both select it.
- Scoreboard state: cnt[r] is LAT_W bits, one per register. cnt[0] is hardwired 0.
- stall = id_valid && ((id_use_rs1 && cnt[id_rs1] != 0) || (id_use_rs2 && cnt[id_rs2] != 0)).
- Issue: issue = id_valid && !stall && !pipe_hold && !flush.
- Per-cycle update, in priority order:
  1. flush: all cnt cleared to 0 next cycle. Issue is ignored that cycle.
  2. pipe_hold (and no flush): all cnt hold. No issue occurs.
  3. Otherwise, every nonzero cnt decrements by 1. If issue && id_we && id_rd != 0, cnt[id_rd] is loaded with id_lat; the load overrides the decrement for that entry.
- Issue with id_lat = 0 writes 0. A younger ALU write to a busy rd therefore clears its pending entry (WAW: the later write wins, in-order pipeline).
- Load-use timing: a load issued with id_lat = 1 causes exactly one stall cycle for a dependant directly behind it. id_lat = L causes L stall cycles.
- Counters never wrap; decrement is applied only to nonzero entries.
- stall_cnt:
  - Increments when stall && !pipe_hold && !flush.
  - Saturates at all-ones.
  - cnt_clr takes priority over increment, and the counter is 0 next cycle.
- Reset (asynchronous, rst_n low): all cnt = 0, stall_cnt = 0, busy_vec = 0, so stall = 0. Reset asserted mid-countdown discards all pending entries immediately.
- x0 never forwards, never stalls and is never busy, whatever the inputs.

Test Plan:
- Forwarding priority: stage_we=2'b11, stage_rd[0]=5, stage_rd[1]=5, ex_rs1=5, ex_rs2=5 -> fwd_a=1, fwd_b=1. Then stage_we=2'b10 -> fwd_a=2, fwd_b=2.
- Independent operands: stage_rd[0]=3, stage_rd[1]=4, both we, ex_rs1=3, ex_rs2=4 -> fwd_a=1, fwd_b=2. rd=0 with we=1 and ex_rs1=0 -> fwd_a=0.
- Load-use: issue id_rd=7, id_lat=1; next cycle id_rs1=7, id_use_rs1=1 -> stall=1 for exactly one cycle, busy_vec[7] high for one cycle; stall_cnt += 1.
- Multi-cycle with hold: issue id_rd=9, id_lat=4, dependant in ID, pipe_hold high for 2 of the cycles -> stall for 6 cycles total; stall_cnt increments 4.
- WAW and flush: issue rd=9 lat=4, then ALU rd=9 lat=0 -> busy_vec[9]=0 next cycle. Issue rd=10 lat=5, then flush -> busy_vec all 0, stall=0 next cycle, and the instruction present during flush is not recorded.
- Reset and saturation: rst_n low mid-countdown -> busy_vec=0 and stall_cnt=0 asynchronously. With CNT_W forced to 4, 20 stall cycles -> stall_cnt=15; cnt_clr -> 0.
